// File: rtl/div4bits_seq.sv
// Sequential restoring divider: unsigned quotient/remainder, one quotient bit per clock.
// Divide-by-zero completes in one cycle with quotient all ones and remainder = dividend.
//  state | meaning
//  IDLE  | waiting for start; results held
//  CALC  | one restoring step per clock, WIDTH steps
//  DZ    | divisor was zero; publish saturated result next edge
module div4bits_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DZ} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;

    logic [WIDTH:0]   t;
    logic [1:0]       sub_hi;
    logic [WIDTH-1:0] sub_lo;
    logic             ge;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;
    logic             accept;
    logic             last;

    assign accept = start && (state == IDLE);
    assign last   = (state == CALC) && (cnt == '0);

    // R < D after every step, so the stored partial remainder fits in WIDTH bits and
    // a successful subtract leaves both upper bits of the (WIDTH+2)-bit result clear.
    always_comb begin
        t                = {r_reg, q_reg[WIDTH-1]};
        {sub_hi, sub_lo} = {1'b0, t} - {2'b00, d_reg};
        ge               = (sub_hi == 2'b00);
        r_nx             = ge ? sub_lo : t[WIDTH-1:0];
        q_nx             = {q_reg[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (divisor == '0) ? DZ : CALC;
            CALC:    if (last) state_nx = IDLE;
            DZ:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= CW'(WIDTH - 1);
                        r_reg <= '0;
                        q_reg <= dividend;
                        d_reg <= divisor;
                    end
                end
                CALC: begin
                    r_reg <= r_nx;
                    q_reg <= q_nx;
                    if (last) begin
                        done      <= 1'b1;
                        quotient  <= q_nx;
                        remainder <= r_nx;
                        div_zero  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DZ: begin
                    done      <= 1'b1;
                    quotient  <= '1;
                    remainder <= q_reg;
                    div_zero  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
